// File: rtl/cp0_pkg.sv
//------------------------------------------------------------------------------
// Module   : cp0_pkg
// Purpose  : Shared definitions for the CP0 coprocessor: register numbers,
//            exception codes, SR/Cause field positions and the EPC capture
//            helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cp0_pkg;

  // CP0 register numbers as seen by mfc0/mtc0
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  // Exception codes carried in Cause.ExcCode
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // SR / Cause field positions
  localparam int SR_IE_BIT     = 0;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IM_LO      = 10;
  localparam int CAUSE_EXC_LO  = 2;
  localparam int CAUSE_IP_LO   = 10;
  localparam int CAUSE_BD_BIT  = 31;

  // Return address for a faulting instruction: a delay-slot instruction
  // restarts at its branch, one word earlier (wraps naturally at 0).
  function automatic logic [29:0] epc_capture(input logic [29:0] pc,
                                              input logic        bd);
    return bd ? (pc - 30'd1) : pc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_timer.sv
//------------------------------------------------------------------------------
// Module   : cp0_timer
// Purpose  : Count/Compare timer. Count increments every clock, Compare is
//            software-loaded; a match raises a sticky pending flag that is
//            cleared by writing Compare.
// Ports    : clk, reset (async active-low), we_count, we_compare, din[31:0],
//            count[31:0], compare[31:0], timer_pend
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_count,
  input  logic        we_compare,
  input  logic [31:0] din,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_pend
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pend_q, pend_d;

  always_comb begin
    count_d   = we_count ? din : (count_q + 32'd1);
    compare_d = we_compare ? din : compare_q;
    // Writing Compare acknowledges the timer interrupt.
    pend_d    = we_compare ? 1'b0 : (pend_q | (count_q == compare_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      pend_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end

  assign count      = count_q;
  assign compare    = compare_q;
  assign timer_pend = pend_q;

endmodule

`default_nettype wire

// File: rtl/cp0.sv
//------------------------------------------------------------------------------
// Module   : cp0
// Purpose  : Coprocessor 0 for the P7 pipeline. Holds SR/Cause/EPC/PRId,
//            merges hardware interrupts with the M-stage exception code and
//            raises IntReq to flush and redirect. Serves mfc0/mtc0 and eret.
// Ports    : clk, reset (async active-low), A1 (mfc0 reg), A2 (mtc0 reg),
//            DIn, WE, PC[31:2], BD, ExcCode_in, HWInt[7:2], EXLClr,
//            IntReq, EPC[31:2], DOut
// Config   : CP0_TIMER_EN - adds Count(9)/Compare(11) timer on IP[15]
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID     = 32'h2019_0001,
  parameter int          HW_INT_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          A1,
  input  logic [4:0]          A2,
  input  logic [31:0]         DIn,
  input  logic                WE,
  input  logic [29:0]         PC,
  input  logic                BD,
  input  logic [4:0]          ExcCode_in,
  input  logic [HW_INT_W-1:0] HWInt,
  input  logic                EXLClr,
  output logic                IntReq,
  output logic [29:0]         EPC,
  output logic [31:0]         DOut
);

  logic [HW_INT_W-1:0] im_q, im_d;
  logic                exl_q, exl_d;
  logic                ie_q, ie_d;
  logic                bd_q, bd_d;
  logic [HW_INT_W-1:0] ip_q, ip_d;
  logic [4:0]          exc_q, exc_d;
  logic [29:0]         epc_q, epc_d;

  logic [HW_INT_W-1:0] hw_eff;
  logic                int_pend;
  logic                exc_pend;
  logic                take;
  logic                mtc0_ok;
  logic [31:0]         sr_val;
  logic [31:0]         cause_val;

  // mtc0 only lands when no interrupt/exception is being taken this cycle.
  assign mtc0_ok = WE & ~take;

`ifdef CP0_TIMER_EN
  logic [31:0] count_val;
  logic [31:0] compare_val;
  logic        timer_pend;

  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .we_count   (mtc0_ok & (A2 == REG_COUNT)),
    .we_compare (mtc0_ok & (A2 == REG_COMPARE)),
    .din        (DIn),
    .count      (count_val),
    .compare    (compare_val),
    .timer_pend (timer_pend)
  );

  // Timer shares the top interrupt line (IP[15]) with HWInt[7].
  assign hw_eff = HWInt | {timer_pend, {(HW_INT_W-1){1'b0}}};
`else
  assign hw_eff = HWInt;
`endif

  assign int_pend = (|(hw_eff & im_q)) & ie_q & ~exl_q;
  assign exc_pend = (ExcCode_in != 5'd0) & ~exl_q;
  assign take     = int_pend | exc_pend;
  assign IntReq   = reset & take;

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = hw_eff;
    exc_d = exc_q;
    epc_d = epc_q;
    if (take) begin
      // Interrupts win over a simultaneous exception.
      exl_d = 1'b1;
      exc_d = int_pend ? EXC_INT : ExcCode_in;
      bd_d  = BD;
      epc_d = epc_capture(PC, BD);
    end else begin
      if (WE && (A2 == REG_SR)) begin
        im_d  = DIn[SR_IM_LO +: HW_INT_W];
        exl_d = DIn[SR_EXL_BIT];
        ie_d  = DIn[SR_IE_BIT];
      end
      if (WE && (A2 == REG_EPC)) begin
        epc_d = DIn[31:2];
      end
      // eret beats a same-cycle SR write, but only for the EXL bit.
      if (EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= 5'd0;
      epc_q <= 30'd0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  assign sr_val    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_val = {bd_q, 15'b0, ip_q, 3'b0, exc_q, 2'b0};
  assign EPC       = epc_q;

  always_comb begin
    DOut = 32'd0;
    case (A1)
      REG_SR:      DOut = sr_val;
      REG_CAUSE:   DOut = cause_val;
      REG_EPC:     DOut = {epc_q, 2'b00};
      REG_PRID:    DOut = PRID;
`ifdef CP0_TIMER_EN
      REG_COUNT:   DOut = count_val;
      REG_COMPARE: DOut = compare_val;
`endif
      default:     DOut = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cp0.sv
//------------------------------------------------------------------------------
// Module   : tb_cp0
// Purpose  : Directed self-checking bench for cp0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cp0;

  localparam logic [31:0] PRID = 32'h2019_0001;

  logic        clk;
  logic        reset;
  logic [4:0]  A1, A2;
  logic [31:0] DIn;
  logic        WE;
  logic [29:0] PC;
  logic        BD;
  logic [4:0]  ExcCode_in;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [29:0] EPC;
  logic [31:0] DOut;

  int n_total = 0;
  int n_pass  = 0;

  cp0 #(.PRID(PRID), .HW_INT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .A1         (A1),
    .A2         (A2),
    .DIn        (DIn),
    .WE         (WE),
    .PC         (PC),
    .BD         (BD),
    .ExcCode_in (ExcCode_in),
    .HWInt      (HWInt),
    .EXLClr     (EXLClr),
    .IntReq     (IntReq),
    .EPC        (EPC),
    .DOut       (DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; inputs change 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational read of a CP0 register.
  task automatic rd(input logic [4:0] r, input string tag, input logic [31:0] exp);
    A1 = r;
    #1;
    chk(tag, DOut, exp);
  endtask

  initial begin
    reset = 1'b0; A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; WE = 1'b0;
    PC = 30'd0; BD = 1'b0; ExcCode_in = 5'd0; HWInt = 6'h3F; EXLClr = 1'b0;

    // Reset state
    tick(); tick();
    #1;
    chk("rst_intreq", {31'd0, IntReq}, 32'd0);
    rd(5'd12, "rst_sr",    32'd0);
    rd(5'd13, "rst_cause", 32'd0);
    rd(5'd14, "rst_epc",   32'd0);
    rd(5'd15, "rst_prid",  PRID);
    reset = 1'b1;
    tick();
    chk("intreq_im0", {31'd0, IntReq}, 32'd0);
    HWInt = 6'h00;
    tick();

    // Interrupt on HWInt[2]
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
    tick();
    WE = 1'b0; HWInt = 6'h01; PC = 30'h0C00;
    #1;
    chk("int_req", {31'd0, IntReq}, 32'd1);
    rd(5'd12, "sr_written", 32'h0000_FC01);
    tick();
    HWInt = 6'h00;
    #1;
    chk("int_exl_block", {31'd0, IntReq}, 32'd0);
    rd(5'd12, "int_sr",    32'h0000_FC03);
    rd(5'd13, "int_cause", 32'h0000_0400);
    rd(5'd14, "int_epc_rd", 32'h0000_3000);
    chk("int_epc", {2'b0, EPC}, 32'h0000_0C00);

    // eret, then Ov in a delay slot
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    rd(5'd12, "eret_sr", 32'h0000_FC01);
    ExcCode_in = 5'd12; BD = 1'b1; PC = 30'h0C05;
    #1;
    chk("ov_req", {31'd0, IntReq}, 32'd1);
    tick();
    #1;
    chk("ov_second_blocked", {31'd0, IntReq}, 32'd0);
    rd(5'd13, "ov_cause", 32'h8000_0030);
    chk("ov_epc", {2'b0, EPC}, 32'h0000_0C04);
    ExcCode_in = 5'd0; BD = 1'b0;

    // Interrupt + exception + mtc0 EPC in the same cycle
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    HWInt = 6'h01; ExcCode_in = 5'd10; WE = 1'b1; A2 = 5'd14;
    DIn = 32'hDEAD_BEEF; PC = 30'h1234;
    #1;
    chk("mix_req", {31'd0, IntReq}, 32'd1);
    tick();
    HWInt = 6'h00; ExcCode_in = 5'd0; WE = 1'b0;
    rd(5'd13, "mix_cause", 32'h0000_0400);
    chk("mix_epc", {2'b0, EPC}, 32'h0000_1234);

    // EXLClr and SR write together: EXL cleared, other fields written
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC03; EXLClr = 1'b1;
    tick();
    WE = 1'b0; EXLClr = 1'b0;
    rd(5'd12, "exlclr_vs_we", 32'h0000_FC01);

    // eret with an interrupt held: IntReq returns the cycle after
    HWInt = 6'h01;
    tick();
    EXLClr = 1'b1;
    #1;
    chk("held_blocked", {31'd0, IntReq}, 32'd0);
    tick();
    EXLClr = 1'b0;
    rd(5'd12, "held_exl0", 32'h0000_FC01);
    chk("held_req", {31'd0, IntReq}, 32'd1);

    // Reset pulse mid-flight
    reset = 1'b0;
    #1;
    chk("midrst_intreq", {31'd0, IntReq}, 32'd0);
    rd(5'd12, "midrst_sr", 32'd0);
    rd(5'd14, "midrst_epc", 32'd0);
    HWInt = 6'h00;
    tick();
    reset = 1'b1;
    tick();
    rd(5'd13, "midrst_cause", 32'd0);
    chk("midrst_epc_port", {2'b0, EPC}, 32'd0);

    // EPC wrap: delay-slot AdEL at PC 0
    ExcCode_in = 5'd4; BD = 1'b1; PC = 30'd0;
    tick();
    ExcCode_in = 5'd0; BD = 1'b0;
    chk("wrap_epc", {2'b0, EPC}, 32'h3FFF_FFFF);
    rd(5'd13, "wrap_cause", 32'h8000_0010);

    // Cause and PRId are not writable; plain EPC write lands
    WE = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
    tick();
    A2 = 5'd15;
    tick();
    A2 = 5'd14; DIn = 32'h1234_5678;
    tick();
    WE = 1'b0;
    rd(5'd13, "cause_ro", 32'h8000_0010);
    rd(5'd15, "prid_ro", PRID);
    rd(5'd14, "epc_write", 32'h1234_5678);
    chk("epc_write_port", {2'b0, EPC}, 32'h048D_159E);
    rd(5'd0, "unmapped", 32'd0);

    // IP follows HWInt with one cycle of latency
    HWInt = 6'h20;
    rd(5'd13, "ip_latency0", 32'h8000_0010);
    tick();
    rd(5'd13, "ip_latency1", 32'h8000_8010);
    HWInt = 6'h00;
    tick();

`ifdef CP0_TIMER_EN
    begin
      bit seen;
      seen = 1'b0;
      WE = 1'b1; A2 = 5'd12; DIn = 32'd0;
      tick();
      A2 = 5'd9; DIn = 32'd0;
      tick();
      A2 = 5'd11; DIn = 32'd5;
      tick();
      WE = 1'b0;
      A1 = 5'd13;
      for (int i = 0; i < 20 && !seen; i++) begin
        #1;
        if (DOut[15]) seen = 1'b1;
        else tick();
      end
      chk("timer_ip15", {31'd0, seen}, 32'd1);
      WE = 1'b1; A2 = 5'd11; DIn = 32'hFFFF_0000;
      tick();
      WE = 1'b0;
      tick();
      rd(5'd13, "timer_clear", 32'h8000_0010);
    end
`else
    WE = 1'b1; A2 = 5'd9; DIn = 32'h5555_AAAA;
    tick();
    A2 = 5'd11;
    tick();
    WE = 1'b0;
    rd(5'd9,  "count_absent",   32'd0);
    rd(5'd11, "compare_absent", 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
